// File: rtl/data_link_pkg.sv
// Shared link constants and receiver state encoding,
// used by both the serializer and the receiver.
package data_link_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } rx_state_t;

  localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hBC;
  localparam int DEFAULT_FRAME_WORDS = 16;
  localparam int WORD_BITS = 8;

endpackage

// File: rtl/data_rx_align_fsm.sv
// Alignment state machine: confirm/miss tracking, lock and strobes.
// DATA_RX_STATS_EN adds saturating error and lock-loss counters.
module data_rx_align_fsm
  import data_link_pkg::*;
#(
  parameter int SYNC_CONFIRM = 2,
  parameter int SYNC_LOSS = 3
) (
  input  logic      clk_400MHz,
  input  logic      reset,
  input  logic      is_sync,
  input  logic      word_done,
  input  logic      sync_slot,
  output rx_state_t state,
  output logic      locked,
  output logic      sync_seen,
  output logic      align_err
`ifdef DATA_RX_STATS_EN
  ,
  output logic [15:0] err_count,
  output logic [15:0] lock_loss_count
`endif
);

  localparam int CW = $clog2(SYNC_CONFIRM + 1);
  localparam int MW = $clog2(SYNC_LOSS + 1);

  logic [CW-1:0] confirm_cnt;
  logic [MW-1:0] miss_cnt;
  logic          slot_done;

  assign slot_done = word_done && sync_slot;

  always_ff @(posedge clk_400MHz or posedge reset) begin
    if (reset) begin
      state       <= SEARCH;
      confirm_cnt <= '0;
      miss_cnt    <= '0;
      locked      <= 1'b0;
      sync_seen   <= 1'b0;
      align_err   <= 1'b0;
`ifdef DATA_RX_STATS_EN
      err_count       <= '0;
      lock_loss_count <= '0;
`endif
    end else begin
      sync_seen <= 1'b0;
      align_err <= 1'b0;
      unique case (state)
        SEARCH: begin
          if (is_sync) begin
            state       <= VERIFY;
            confirm_cnt <= '0;
          end
        end
        VERIFY: begin
          if (slot_done && is_sync) begin
            sync_seen <= 1'b1;
            if (confirm_cnt + CW'(1) == CW'(SYNC_CONFIRM)) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              miss_cnt <= '0;
            end else begin
              confirm_cnt <= confirm_cnt + CW'(1);
            end
          end else if (slot_done) begin
            align_err <= 1'b1;
            state     <= SEARCH;
`ifdef DATA_RX_STATS_EN
            if (err_count != '1) err_count <= err_count + 16'd1;
`endif
          end
        end
        LOCKED: begin
          if (slot_done && is_sync) begin
            sync_seen <= 1'b1;
            miss_cnt  <= '0;
          end else if (slot_done) begin
            align_err <= 1'b1;
`ifdef DATA_RX_STATS_EN
            if (err_count != '1) err_count <= err_count + 16'd1;
`endif
            // flywheel: keep alignment until too many misses in a row
            if (miss_cnt + MW'(1) == MW'(SYNC_LOSS)) begin
              state    <= SEARCH;
              locked   <= 1'b0;
              miss_cnt <= '0;
`ifdef DATA_RX_STATS_EN
              if (lock_loss_count != '1)
                lock_loss_count <= lock_loss_count + 16'd1;
`endif
            end else begin
              miss_cnt <= miss_cnt + MW'(1);
            end
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: rtl/data_rx_deser.sv
// Serial-to-parallel receiver with sync-word frame alignment.
// Optional DATA_RX_STATS_EN exposes err_count / lock_loss_count.
module data_rx_deser
  import data_link_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD = DEFAULT_SYNC_WORD,
  parameter int FRAME_WORDS = DEFAULT_FRAME_WORDS,
  parameter int SYNC_CONFIRM = 2,
  parameter int SYNC_LOSS = 3
) (
  input  logic       clk_400MHz,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       sync_seen,
  output logic       locked,
  output logic       align_err
`ifdef DATA_RX_STATS_EN
  ,
  output logic [15:0] err_count,
  output logic [15:0] lock_loss_count
`endif
);

  localparam int WCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  // only 7 history bits are stored; cand supplies the newest one
  logic [6:0]     sr;
  logic [7:0]     cand;
  logic [2:0]     bit_cnt;
  logic [WCW-1:0] word_cnt;
  logic           is_sync;
  logic           word_done;
  logic           sync_slot;
  rx_state_t      state;

  assign cand      = {sr, data_in};
  assign is_sync   = cand == SYNC_WORD;
  assign sync_slot = word_cnt == '0;
  assign word_done = (state != SEARCH) &&
                     (bit_cnt == 3'(WORD_BITS - 1));

  always_ff @(posedge clk_400MHz or posedge reset) begin
    if (reset) begin
      sr         <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      sr         <= cand[6:0];
      data_valid <= 1'b0;
      if (state == SEARCH) begin
        if (is_sync) begin
          bit_cnt  <= '0;
          word_cnt <= WCW'(1);
        end
      end else begin
        bit_cnt <= bit_cnt + 3'd1;
        if (word_done) begin
          word_cnt <= (word_cnt == WCW'(FRAME_WORDS - 1)) ?
                      '0 : word_cnt + WCW'(1);
          if (state == LOCKED && !sync_slot) begin
            data_out   <= cand;
            data_valid <= 1'b1;
          end
        end
      end
    end
  end

  data_rx_align_fsm #(
    .SYNC_CONFIRM(SYNC_CONFIRM),
    .SYNC_LOSS(SYNC_LOSS)
  ) u_fsm (
    .clk_400MHz(clk_400MHz),
    .reset(reset),
    .is_sync(is_sync),
    .word_done(word_done),
    .sync_slot(sync_slot),
    .state(state),
    .locked(locked),
    .sync_seen(sync_seen),
    .align_err(align_err)
`ifdef DATA_RX_STATS_EN
    ,
    .err_count(err_count),
    .lock_loss_count(lock_loss_count)
`endif
  );

endmodule

// File: tb/tb_data_rx_deser.sv
// Self-checking bench for data_rx_deser: vector table, directed
// corner sequences and random frames against an anchor-based model.
module tb_data_rx_deser;

  localparam logic [7:0] SW = 8'hBC;
  localparam int FW = 16;
  localparam int CONF = 2;
  localparam int LOSS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic [7:0] dout;
  logic       dv, ss, lk, ae;
`ifdef DATA_RX_STATS_EN
  logic [15:0] errc, llc;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_rx_deser dut (
    .clk_400MHz(clk),
    .reset(rst),
    .data_in(din),
    .data_out(dout),
    .data_valid(dv),
    .sync_seen(ss),
    .locked(lk),
    .align_err(ae)
`ifdef DATA_RX_STATS_EN
    ,
    .err_count(errc),
    .lock_loss_count(llc)
`endif
  );

  // Reference model: alignment is an anchor time; word k of the
  // frame completes 8*k edges after the anchor.
  typedef enum {M_SEARCH, M_VERIFY, M_LOCKED} m_mode_t;
  m_mode_t     m_mode;
  int unsigned m_t, m_anchor;
  int          m_conf, m_miss;
  logic [7:0]  m_hist;
  logic [7:0]  e_dout;
  logic        e_dv, e_ss, e_ae, e_lk;
  int          e_err, e_ll;

  function automatic void model_reset();
    m_mode = M_SEARCH;
    m_t = 0; m_anchor = 0; m_conf = 0; m_miss = 0;
    m_hist = '0; e_dout = '0;
    e_dv = 0; e_ss = 0; e_ae = 0; e_lk = 0;
    e_err = 0; e_ll = 0;
  endfunction

  function automatic void model_edge(input logic b);
    int unsigned k;
    m_hist = {m_hist[6:0], b};
    m_t++;
    e_dv = 0; e_ss = 0; e_ae = 0;
    if (m_mode == M_SEARCH) begin
      if (m_hist == SW) begin
        m_mode = M_VERIFY; m_anchor = m_t; m_conf = 0;
      end
    end else if ((m_t - m_anchor) % 8 == 0) begin
      k = (m_t - m_anchor) / 8;
      if (k % FW != 0) begin
        if (m_mode == M_LOCKED) begin
          e_dv = 1; e_dout = m_hist;
        end
      end else if (m_hist == SW) begin
        e_ss = 1;
        if (m_mode == M_VERIFY) begin
          m_conf++;
          if (m_conf == CONF) begin
            m_mode = M_LOCKED; e_lk = 1; m_miss = 0;
          end
        end else m_miss = 0;
      end else begin
        e_ae = 1;
        if (e_err < 65535) e_err++;
        if (m_mode == M_VERIFY) m_mode = M_SEARCH;
        else begin
          m_miss++;
          if (m_miss == LOSS) begin
            m_mode = M_SEARCH; e_lk = 0; m_miss = 0;
            if (e_ll < 65535) e_ll++;
          end
        end
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic step(input logic b);
    din = b;
    @(posedge clk);
    model_edge(b);
    #1;
    chk("cycle", {20'd0, dv, ss, ae, lk, dout},
        {20'd0, e_dv, e_ss, e_ae, e_lk, e_dout});
`ifdef DATA_RX_STATS_EN
    chk("stats", {errc, llc}, {16'(e_err), 16'(e_ll)});
`endif
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(v[i]);
  endtask

  task automatic send_payload(output int nv);
    nv = 0;
    for (int w = 1; w < FW; w++) begin
      send_byte(8'(w));
      nv += int'(dv);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_out", {dout, dv, ss, lk, ae}, 12'd0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic acquire();
    int nv;
    logic [1:0] want;
    for (int f = 0; f < 3; f++) begin
      send_byte(SW);
      want = (f == 0) ? 2'b00 : (f == 1) ? 2'b10 : 2'b11;
      chk("acq_ss_lk", {ss, lk}, want);
      if (f < 2) begin
        send_payload(nv);
        chk("acq_no_dv", nv, 0);
      end
    end
  endtask

  task automatic loss_run();
    int nv;
    acquire();
    send_payload(nv);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h00);
      send_payload(nv);
    end
  endtask

  typedef struct {
    logic [7:0] bv;
    logic       dv;
    logic [7:0] dout;
    logic       ss;
    logic       lk;
  } vec_t;

  vec_t tbl[49];

  initial begin
    int idx, nv, cnt;
    logic [7:0] held, bv;
    model_reset();

    idx = 0;
    held = 8'h00;
    for (int f = 0; f < 3; f++) begin
      for (int w = 0; w < FW; w++) begin
        bv = (w == 0) ? SW : 8'(w);
        tbl[idx].bv = bv;
        tbl[idx].dv = (f == 2 && w != 0);
        if (tbl[idx].dv) held = bv;
        tbl[idx].dout = held;
        tbl[idx].ss = (w == 0 && f >= 1);
        tbl[idx].lk = (f == 2);
        idx++;
      end
    end
    tbl[48] = '{SW, 1'b0, held, 1'b1, 1'b1};

    // idle zeros
    do_reset();
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      step(1'b0);
      cnt += int'(dv) + int'(ss) + int'(ae);
    end
    chk("idle_strobes", cnt, 0);
    chk("idle_out", {dout, lk}, 9'd0);

    // clean acquisition from vector table
    do_reset();
    step(1'b1); step(1'b0); step(1'b1);
    for (int i = 0; i < 49; i++) begin
      send_byte(tbl[i].bv);
      chk("tbl_dv", dv, tbl[i].dv);
      chk("tbl_dout", dout, tbl[i].dout);
      chk("tbl_ss", ss, tbl[i].ss);
      chk("tbl_lk", lk, tbl[i].lk);
    end

    // false sync: verify window rejects misplaced sync
    do_reset();
    send_byte(8'h00);
    send_byte(SW);
    chk("fs_det", {ss, ae, lk}, 3'b000);
    for (int i = 1; i < FW; i++) send_byte(8'h11);
    send_byte(8'h22);
    chk("fs_aerr", {ae, lk}, 2'b10);
    send_byte(8'h11);
    chk("fs_after", {ae, lk}, 2'b00);

    // flywheel then loss
    do_reset();
    acquire();
    send_payload(nv);
    chk("fw_dv0", nv, 15);
    for (int i = 0; i < 2; i++) begin
      send_byte(8'h00);
      chk("fw_miss", {ae, lk}, 2'b11);
      send_payload(nv);
      chk("fw_dv", nv, 15);
    end
    send_byte(SW);
    chk("fw_resync", {ss, ae, lk}, 3'b101);
    send_payload(nv);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h00);
      chk("loss_lk", {ae, lk}, {1'b1, (i < 2) ? 1'b1 : 1'b0});
      send_payload(nv);
      chk("loss_dv", nv, (i < 2) ? 15 : 0);
    end

    // reset mid-word while locked
    do_reset();
    acquire();
    send_payload(nv);
    send_byte(SW);
    for (int i = 0; i < 4; i++) step(1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_out", {dout, dv, ss, lk, ae}, 12'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_hold", {dv, lk}, 2'd0);
    rst = 1'b0;
    model_reset();
    acquire();

`ifdef DATA_RX_STATS_EN
    do_reset();
    loss_run();
    loss_run();
    chk("stat_err", errc, 16'd6);
    chk("stat_loss", llc, 16'd2);
`endif

    // random frames, slips and corrupted syncs
    do_reset();
    for (int i = 0; i < 3; i++) step(1'($urandom));
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 9) == 0)
        repeat ($urandom_range(1, 3)) step(1'($urandom));
      send_byte(($urandom_range(0, 7) == 0) ? 8'($urandom) : SW);
      for (int w = 1; w < FW; w++) send_byte(8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_rx_deser.md
Name: data_rx_deser

Overview:
- Serial-to-parallel receiver for the 8-bit MSB-first bitstream produced by the team's 400 MHz serializer.
- Samples one bit per clk_400MHz edge and hunts for a sync byte to find word alignment. Alignment is confirmed over several frames before payload bytes are presented with a one-cycle valid strobe.
- Sits at the link input, ahead of the payload consumer logic.

Parameters:
- SYNC_WORD, 8'hBC, alignment byte; always occupies word 0 of every frame.
- FRAME_WORDS, 16, words per frame including the sync word; legal range 2..256.
- SYNC_CONFIRM, 2, consecutive correctly placed sync words required after first detection before lock.
- SYNC_LOSS, 3, consecutive missing sync words while locked that cause loss of lock.

Ports:
- clk_400MHz  input  1  bit clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  1  serial bit, MSB of each word first.
- data_out  output  8  last completed payload word.
- data_valid  output  1  one-cycle strobe; data_out holds a new payload word.
- sync_seen  output  1  one-cycle strobe; a sync word was found in its expected slot.
- locked  output  1  high while in LOCKED.
- align_err  output  1  one-cycle strobe; expected sync slot held a non-sync word (VERIFY or LOCKED).

Behaviour:
- Reset: all outputs 0; shift register 0; bit_cnt 0, word_cnt 0, confirm_cnt 0, miss_cnt 0; state SEARCH. Reset mid-word discards the partial word; no strobe is issued.
- Shift: every edge, sr <= {sr[6:0], data_in}. Define cand = {sr[6:0], data_in}, the newest 8 bits including this edge's bit.
- SEARCH: compare cand to SYNC_WORD every edge. On match: bit_cnt <= 0, word_cnt <= 1, confirm_cnt <= 0, go to VERIFY. No data_valid, no sync_seen.
- Word timing outside SEARCH: bit_cnt increments 0..7 and wraps. The edge where bit_cnt==7 is the word-complete edge; cand is the word. On that edge, word_cnt increments modulo FRAME_WORDS. A word completing with word_cnt==0 is the sync slot.
- VERIFY:
  - Sync slot equal to SYNC_WORD: pulse sync_seen. confirm_cnt+1; if it reaches SYNC_CONFIRM, go to LOCKED and set locked on the same edge.
  - Sync slot mismatch: pulse align_err and return to SEARCH.
  - Payload words: not presented.
- LOCKED:
  - Payload word (word_cnt!=0): data_out <= cand, data_valid pulses for one cycle.
  - Sync slot match: pulse sync_seen, clear miss_cnt.
  - Sync slot mismatch: pulse align_err, miss_cnt+1. Alignment is held (flywheel). When miss_cnt reaches SYNC_LOSS, go to SEARCH and clear locked on that edge.
- Latency: data_valid and data_out update on the edge that samples the word's LSB; visible the following cycle.
- data_out holds its value between strobes.
- Back-to-back data_valid pulses are spaced exactly 8 cycles apart.
- Payload bytes equal to SYNC_WORD are legal. In LOCKED they are output as data, not treated as sync. In SEARCH they can cause false detection, which VERIFY rejects.
- Counter widths: bit_cnt 3 bits, word_cnt clog2(FRAME_WORDS), confirm_cnt and miss_cnt sized to their thresholds.

Optional Feature:
- Macro DATA_RX_STATS_EN.
- With it defined, the block adds two outputs, each a 16-bit saturating counter cleared only by reset:
  - err_count: increments on each align_err.
  - lock_loss_count: increments on each LOCKED->SEARCH transition.
- Without it, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package data_link_pkg holds:
  - the state enum (SEARCH, VERIFY, LOCKED);
  - DEFAULT_SYNC_WORD (8'hBC), DEFAULT_FRAME_WORDS, WORD_BITS = 8.
- The serializer uses the same package constants.
- One natural sub-module: data_rx_align_fsm, containing the state, confirm/miss counters and lock/strobe generation. The top level keeps the shift register, bit/word counters and output registers.

Test Plan:
- Reset then idle zeros: data_in=0 for 200 cycles -> state SEARCH, no strobes, all outputs 0.
- Clean acquisition: 3 bits of garbage, then frames of BC, 01..0F -> sync_seen at each sync slot. locked rises on the edge completing the 3rd sync. Next frame produces data_valid x15 with data_out 01..0F, 8 cycles apart.
- False sync in SEARCH: payload byte BC with wrong frame spacing -> VERIFY entered, first sync slot mismatch -> align_err pulse, back to SEARCH, locked never set.
- Flywheel and loss: locked link, corrupt 2 consecutive sync words to 00 -> 2 align_err pulses, locked stays 1, payload still output. 3 consecutive corruptions -> locked falls on the 3rd, no further data_valid.
- Reset mid-word: assert reset after 4 bits of a payload word while locked -> outputs 0 immediately, no data_valid, re-acquisition needs the full confirm sequence.
- With DATA_RX_STATS_EN: run the loss scenario twice -> err_count=6, lock_loss_count=2.
